hex_display_scanner: RTL

//  Parametrised N-digit time-multiplexed hex display driver for processor debug boards.

---
 rtl/hex_display_scanner.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexed hex display driver for processor debug boards. Shows one
//   page (NUM_DIGITS nibbles) of word_a or word_b, with optional leading-zero
//   blanking. Debounces a page-advance button and a single-step button; the
//   latter produces a one-cycle step_pulse.
// Ports
//   clk        system clock, all state on rising edge
//   reset      synchronous, active-high
//   word_a     debug word A (register value), shown when view_sel=1
//   word_b     debug word B (instruction), shown when view_sel=0
//   view_sel   word select
//   lz_blank   blank leading zero digits of the current page
//   page_btn   raw asynchronous page-advance button
//   step_btn   raw asynchronous single-step button
//   seg        segments [0:6] = a..g, active-low
//   anode      one-hot digit enable, polarity set by ACTIVE_LOW_AN
//   page       current page index
//   step_pulse one-cycle pulse per accepted step press
module hex_display_scanner #(
   parameter int NUM_DIGITS    = 4,
   parameter int WORD_W        = 32,
   parameter int REFRESH_DIV   = 50000,
   parameter int DEBOUNCE_CYC  = 500000,
   parameter int ACTIVE_LOW_AN = 1,
   parameter int PAGE_W        =
      (((WORD_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS)) > 1) ?
      $clog2((WORD_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS)) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD_W-1:0]     word_a,
   input  logic [WORD_W-1:0]     word_b,
   input  logic                  view_sel,
   input  logic                  lz_blank,
   input  logic                  page_btn,
   input  logic                  step_btn,
   output logic [0:6]            seg,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [PAGE_W-1:0]     page,
   output logic                  step_pulse
);

   localparam int NUM_PAGES = (WORD_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS);
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int REF_W     = $clog2(REFRESH_DIV);
   localparam int DEB_W     = $clog2(DEBOUNCE_CYC);
   localparam int PAGE_BITS = 4 * NUM_DIGITS;
   // Word zero-padded to cover every page index PAGE_W can express.
   localparam int SPAN_W    = (1 << PAGE_W) * PAGE_BITS;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW_AN != 0) ? '1 : '0;

   // ---------------------------------------------------------------- buttons
   // Bit 0 = page button, bit 1 = step button.
   logic [1:0]       btn_raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       deb_lvl;
   logic [1:0]       deb_prev;
   logic [1:0]       btn_pulse;
   logic [DEB_W-1:0] deb_cnt [2];

   always_comb begin
      btn_raw = {step_btn, page_btn};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         deb_lvl   <= '0;
         deb_prev  <= '0;
         btn_pulse <= '0;
         for (int unsigned b = 0; b < 2; b++) begin
            deb_cnt[b] <= '0;
         end
      end else begin
         sync1     <= btn_raw;
         sync2     <= sync1;
         deb_prev  <= deb_lvl;
         btn_pulse <= deb_lvl & ~deb_prev;
         for (int unsigned b = 0; b < 2; b++) begin
            if (sync2[b] == deb_lvl[b]) begin
               deb_cnt[b] <= '0;
            end else if (deb_cnt[b] == DEB_W'(DEBOUNCE_CYC - 1)) begin
               deb_lvl[b] <= ~deb_lvl[b];
               deb_cnt[b] <= '0;
            end else begin
               deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
            end
         end
      end
   end

   always_comb begin
      step_pulse = btn_pulse[1];
   end

   // ------------------------------------------------------------------- page
   always_ff @(posedge clk) begin
      if (reset) begin
         page <= '0;
      end else if (btn_pulse[0]) begin
         if (page == PAGE_W'(NUM_PAGES - 1)) begin
            page <= '0;
         end else begin
            page <= page + PAGE_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------- scan
   logic [REF_W-1:0] ref_cnt;
   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         ref_cnt <= '0;
         idx     <= '0;
      end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
         ref_cnt <= '0;
         if (idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx <= '0;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end else begin
         ref_cnt <= ref_cnt + REF_W'(1);
      end
   end

   // ------------------------------------------------------- digit selection
   function automatic logic [0:6] hex7(input logic [3:0] n);
      logic [0:6] s;
      unique case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   logic [SPAN_W-1:0]     span;
   logic [PAGE_BITS-1:0]  page_nibs;
   logic [NUM_DIGITS-1:0] tail_zero;   // [i]: nibbles i..NUM_DIGITS-1 all zero
   logic                  zero_run;
   logic [3:0]            cur_nib;
   logic                  blank;
   logic [NUM_DIGITS-1:0] on;
   logic [0:6]            seg_nxt;
   logic [NUM_DIGITS-1:0] anode_nxt;

   always_comb begin
      span = '0;
      span[WORD_W-1:0] = view_sel ? word_a : word_b;
      page_nibs = span[page*PAGE_BITS +: PAGE_BITS];

      // Scan from the most significant digit down, accumulating all-zero runs.
      zero_run  = 1'b1;
      tail_zero = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         zero_run = zero_run & (page_nibs[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
         tail_zero[NUM_DIGITS-1-i] = zero_run;
      end

      cur_nib   = page_nibs[idx*4 +: 4];
      blank     = lz_blank && (idx != '0) && tail_zero[idx];
      on        = blank ? '0 : (NUM_DIGITS'(1) << idx);
      seg_nxt   = blank ? '1 : hex7(cur_nib);
      anode_nxt = (ACTIVE_LOW_AN != 0) ? ~on : on;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg   <= '1;
         anode <= AN_OFF;
      end else begin
         seg   <= seg_nxt;
         anode <= anode_nxt;
      end
   end

endmodule
